// File: rtl/alu_result_fifo.sv
// alu_result_fifo: DEPTH-entry buffer of ALU result + zero/carry/overflow flags, optional sticky status (ALU_STICKY_FLAGS_EN).
// Latency: push to out_valid is 1 cycle, no same-cycle bypass; sustains 1 entry/cycle.
// Backpressure: in_ready = rst_n & !full, never depends on out_ready; a stalled head holds out_* constant.

// Generic single-clock FIFO with registered occupancy and combinational head read.
// Latency: written entry visible at the head one cycle after the push.
// Backpressure: wr_rdy drops when full (or in reset); a pop frees a slot seen by wr_rdy next cycle.
module alu_fifo_core #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Reject unusable geometries at elaboration time; pointer wrap relies on a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_fifo_core: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Ready is gated by reset so upstream never hands over an entry that would be discarded.
  assign wr_rdy = rst_n & (count != FULL);
  assign rd_vld = (count != '0);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_vld & rd_rdy;

  // Head is read straight out of storage; no output register, so a stall cannot change it.
  assign rd_dat = mem[rd_ptr];

  // Storage: cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Write pointer advances per push and wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances per pop and wraps naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// alu_result_fifo: buffers ALU results and flags for a consumer that may stall.
// Latency: 1 cycle push-to-out_valid; 1 entry/cycle when out_ready is held high.
// Backpressure: in_ready low when full or in reset; independent of out_ready (no comb ready path).
module alu_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_result,
  input  logic                   in_zero,
  input  logic                   in_carry,
  input  logic                   in_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_zero,
  output logic                   out_carry,
  output logic                   out_overflow,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic                   sticky_clr,
  output logic                   sticky_carry,
  output logic                   sticky_overflow
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
  } entry_t;

  entry_t wr_entry;
  entry_t rd_entry;

  assign wr_entry.result   = in_result;
  assign wr_entry.zero     = in_zero;
  assign wr_entry.carry    = in_carry;
  assign wr_entry.overflow = in_overflow;

  alu_fifo_core #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_entry),
    .count  (count)
  );

  assign out_result   = rd_entry.result;
  assign out_zero     = rd_entry.zero;
  assign out_carry    = rd_entry.carry;
  assign out_overflow = rd_entry.overflow;

`ifdef ALU_STICKY_FLAGS_EN
  logic push;

  // Only accepted entries contribute to sticky status.
  assign push = in_valid & in_ready;

  // Sticky status accumulates per accepted entry; a setting push beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      if (push && in_carry) begin
        sticky_carry <= 1'b1;
      end else if (sticky_clr) begin
        sticky_carry <= 1'b0;
      end
      if (push && in_overflow) begin
        sticky_overflow <= 1'b1;
      end else if (sticky_clr) begin
        sticky_overflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo (WIDTH=16, DEPTH=4); sticky checks when ALU_STICKY_FLAGS_EN is defined.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Summary line reports total and failed comparison counts.
module tb_alu_result_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_zero;
  logic        in_carry;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_overflow;
  logic [2:0]  count;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic        sticky_carry;
  logic        sticky_overflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  alu_result_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .count        (count)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr      (sticky_clr),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a few hundred time units long.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_zero = 1'b0;
    in_carry = 1'b0; in_overflow = 1'b0; out_ready = 1'b0;
`ifdef ALU_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    #2;
    // Reset state.
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_result", out_result, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single entry, no same-cycle forwarding.
    in_valid = 1'b1; in_result = 16'h1234; in_carry = 1'b1;
    #1;
    check("single_no_bypass", out_valid, 0);
    step();
    in_valid = 1'b0; in_carry = 1'b0;
    check("single_out_valid", out_valid, 1);
    check("single_out_result", out_result, 16'h1234);
    check("single_out_carry", out_carry, 1);
    check("single_out_zero", out_zero, 0);
    check("single_out_overflow", out_overflow, 0);
    check("single_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_valid", out_valid, 0);

    // Fill to full with alternating zero flags, then attempt a fifth push.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_result = 16'(i); in_zero = i[0]; in_overflow = ~i[0];
      step();
    end
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    in_result = 16'h0005; in_zero = 1'b0; in_overflow = 1'b0;
    step();
    in_valid = 1'b0;
    check("blocked_count", count, 4);
    check("stall_head_hold", out_result, 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      out_ready = 1'b1;
      check($sformatf("drain_result_%0d", i), out_result, 32'(i));
      check($sformatf("drain_zero_%0d", i), out_zero, i % 2);
      check($sformatf("drain_ovf_%0d", i), out_overflow, (i + 1) % 2);
      step();
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);

    // Continuous streaming across pointer wrap.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_result = 16'h0010 + 16'(k);
      step();
      check($sformatf("wrap_count_%0d", k), count, 1);
      check($sformatf("wrap_result_%0d", k), out_result, 32'h10 + 32'(k));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("wrap_final_count", count, 0);

    // Full with simultaneous pop: freed slot only visible next cycle.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 16'h0020 + 16'(i);
      step();
    end
    check("fullpop_start_count", count, 4);
    in_result = 16'h0024; out_ready = 1'b1;
    #1;
    check("fullpop_in_ready_c0", in_ready, 0);
    step();
    check("fullpop_c1_count", count, 3);
    check("fullpop_c1_in_ready", in_ready, 1);
    check("fullpop_c1_head", out_result, 16'h0021);
    step();
    in_valid = 1'b0;
    check("fullpop_c2_count", count, 3);
    check("fullpop_c2_head", out_result, 16'h0022);
    check("fullpop_drain_a", out_result, 16'h0022);
    step();
    check("fullpop_drain_b", out_result, 16'h0023);
    step();
    check("fullpop_drain_c", out_result, 16'h0024);
    step();
    out_ready = 1'b0;
    check("fullpop_end_count", count, 0);

    // Asynchronous reset mid-stream with three entries held.
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_result = 16'h0030 + 16'(i);
      step();
    end
    check("midrst_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 16'h0000);
    check("midrst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    check("midrst_release_count", count, 0);

`ifdef ALU_STICKY_FLAGS_EN
    check("sticky_rst_carry", sticky_carry, 0);
    check("sticky_rst_ovf", sticky_overflow, 0);
    in_valid = 1'b1; in_result = 16'h0000; in_zero = 1'b1; in_carry = 1'b1; in_overflow = 1'b0;
    step();
    check("sticky_set_carry", sticky_carry, 1);
    check("sticky_set_ovf", sticky_overflow, 0);
    sticky_clr = 1'b1; in_zero = 1'b0; in_carry = 1'b0; in_overflow = 1'b1; in_result = 16'h8000;
    step();
    check("sticky_clr_carry", sticky_carry, 0);
    check("sticky_clr_ovf", sticky_overflow, 1);
    in_carry = 1'b1; in_overflow = 1'b0;
    step();
    in_valid = 1'b0; sticky_clr = 1'b0; in_carry = 1'b0;
    check("sticky_setwins_carry", sticky_carry, 1);
    check("sticky_clr2_ovf", sticky_overflow, 0);
    check("sticky_fifo_count", count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
